cc_cond_unit: RTL and testbench
===============================

// Module: cc_cond_unit
// PURPOSE
//   Execute-stage condition-code register and condition evaluator, directly downstream of the ALU.
//   Latches the ALU's {ZF,SF,OF} flags for OPq instructions only; gated by stall and exception status.
//   Drives cnd, which selects jXX next-PC and cmovXX register write-back.
//   cnd is computed from the *registered* CC: this cycle's instruction sees flags set by earlier instructions.
// PARAMETERS
//   CC_RESET  3'b100  CC value after reset {ZF,SF,OF}; ZF=1, SF=0, OF=0
//   PERF_W    32      width of performance counters (CC_PERF_EN builds only)
// PORTS
//   clk          in   1   rising-edge clock
//   rst_n        in   1   synchronous active-low reset
//   in_valid     in   1   an instruction is executing this cycle
//   stall        in   1   hold: no state update this cycle
//   stat_ok      in   1   1 = no exception pending for this instruction
//   icode        in   4   instruction code
//   ifun         in   4   function / condition code
//   alu_cc       in   3   flags from ALU: [2]=ZF [1]=SF [0]=OF
//   cc_q         out  3   registered condition codes, same bit order
//   cnd          out  1   condition result for current icode/ifun
//   set_cc       out  1   decoded CC write enable (debug/visibility)
//   perf_cond    out  PERF_W  count of retired jXX/cmovXX (CC_PERF_EN only)
//   perf_taken   out  PERF_W  count of those with cnd=1 (CC_PERF_EN only)
// BEHAVIOUR
//   Reset: cc_q=CC_RESET. Counters=0. Reset on an edge overrides every other input.
//   Decode constants:
//     icode OPq=4'h6, JXX=4'h7, CMOVXX=4'h2.
//   set_cc = in_valid & ~stall & stat_ok & (icode==OPq). Combinational.
//   CC update: at posedge, if set_cc then cc_q<=alu_cc; otherwise hold.
//     One-cycle latency: a following instruction sees the new flags in the next cycle.
//   cnd is combinational from cc_q and ifun, with X = SF^OF:
//     0 always  1
//     1 le      X|ZF
//     2 l       X
//     3 e       ZF
//     4 ne      ~ZF
//     5 ge      ~X
//     6 g       ~X & ~ZF
//     7..15     0 (illegal condition)
//   cnd is only meaningful when icode is JXX or CMOVXX. For any other icode, cnd=0.
//   Simultaneous events:
//     stall=1 with OPq: no CC write.
//     stat_ok=0: no CC write, including for a faulting OPq.
//     in_valid=0: no write, and cnd is still evaluated combinationally.
//   cc_q never changes except by reset or set_cc; no wrap or saturation applies to the flags.
// CONFIGURATION
//   Macro CC_PERF_EN.
//   Defined:
//     perf_cond increments at posedge when in_valid & ~stall & stat_ok & icode is JXX or CMOVXX.
//     perf_taken increments under the same condition and cnd=1.
//     Both counters wrap modulo 2**PERF_W and reset to 0.
//   Undefined:
//     Counter logic is absent; perf_cond and perf_taken are tied to 0; PERF_W is unused.
// STRUCTURE
//   Shared package y86_pkg:
//     icode localparams (OPq, JXX, CMOVXX), ifun condition localparams (C_ALWAYS..C_G).
//     CC bit indices ZF_B=2, SF_B=1, OF_B=0.
//   Sub-module cond_eval (combinational): cc[2:0], ifun[3:0] -> cnd_raw.
//   Top level holds the CC register, set_cc decode, icode gating of cnd, and the optional counters.
// TESTING
//   1. Reset, then JXX with ifun=3 (je): cc_q=3'b100 and cnd=1. Same with ifun=4 (jne): cnd=0.
//   2. OPq with alu_cc=3'b010 (SF set), stat_ok=1, stall=0:
//      set_cc=1; next cycle cc_q=3'b010; JXX with ifun=2 (jl) gives cnd=1 and ifun=5 (jge) gives cnd=0.
//   3. OPq with alu_cc=3'b011 and stall=1: cc_q unchanged. Repeat with stall=0, stat_ok=0: cc_q unchanged.
//   4. Sweep cc_q over all 8 values x ifun 0..15 for JXX and CMOVXX:
//      cnd matches the table and is 0 for ifun>=7. With icode=4'h3, cnd=0 for every value.
//   5. Assert rst_n=0 in the same cycle as a set_cc OPq with alu_cc=3'b001: next cc_q=3'b100.
//   6. CC_PERF_EN with PERF_W=4:
//      18 valid JXX, 10 of them taken, plus 1 stalled and 1 with stat_ok=0.
//      Expect perf_cond=2 (18 wraps modulo 16) and perf_taken=10.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared decode constants for the execute-stage condition-code logic.
//   - icode values for the instructions that touch or consume the flags
//   - ifun condition selectors used by jXX / cmovXX
//   - bit positions of ZF/SF/OF inside the 3-bit CC vector
package y86_pkg;

   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CMOVXX = 4'h2;

   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   localparam int ZF_B = 2;
   localparam int SF_B = 1;
   localparam int OF_B = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator.
//   cc      in  3  registered flags {ZF,SF,OF}
//   ifun    in  4  condition selector
//   cnd_raw out 1  condition result, independent of icode; 0 for ifun >= 7
module cond_eval
   import y86_pkg::*;
(
   input  logic [2:0] cc,
   input  logic [3:0] ifun,
   output logic       cnd_raw
);

   logic zf;
   logic lt;

   always_comb begin
      zf = cc[ZF_B];
      // signed less-than after a subtract: sign disagrees with overflow
      lt = cc[SF_B] ^ cc[OF_B];
      cnd_raw = 1'b0;
      case (ifun)
         C_ALWAYS: cnd_raw = 1'b1;
         C_LE:     cnd_raw = lt | zf;
         C_L:      cnd_raw = lt;
         C_E:      cnd_raw = zf;
         C_NE:     cnd_raw = ~zf;
         C_GE:     cnd_raw = ~lt;
         C_G:      cnd_raw = ~lt & ~zf;
         default:  cnd_raw = 1'b0;
      endcase
   end

endmodule

// File: rtl/cc_cond_unit.sv
// Execute-stage condition-code register and condition evaluator.
// Latches ALU flags for OPq instructions and produces cnd for jXX/cmovXX
// from the registered flags (so an instruction sees flags of earlier ones).
// Optional macro CC_PERF_EN adds retired-conditional / taken counters.
//   clk, rst_n       clock, synchronous active-low reset
//   in_valid, stall  instruction present / hold this cycle
//   stat_ok          no exception pending
//   icode, ifun      instruction and condition codes
//   alu_cc           ALU flags {ZF,SF,OF}
//   cc_q             registered flags
//   cnd              condition result (0 unless icode is JXX or CMOVXX)
//   set_cc           CC write enable
//   perf_cond        retired jXX/cmovXX count (0 without CC_PERF_EN)
//   perf_taken       of those, count with cnd=1 (0 without CC_PERF_EN)
module cc_cond_unit
   import y86_pkg::*;
#(
   parameter logic [2:0] CC_RESET = 3'b100,
   parameter int         PERF_W   = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              stat_ok,
   input  logic [3:0]        icode,
   input  logic [3:0]        ifun,
   input  logic [2:0]        alu_cc,
   output logic [2:0]        cc_q,
   output logic              cnd,
   output logic              set_cc,
   output logic [PERF_W-1:0] perf_cond,
   output logic [PERF_W-1:0] perf_taken
);

   logic [2:0] cc_d;
   logic       cnd_raw;
   logic       is_cond;

   cond_eval u_cond_eval (
      .cc      (cc_q),
      .ifun    (ifun),
      .cnd_raw (cnd_raw)
   );

   always_comb begin
      set_cc  = in_valid & ~stall & stat_ok & (icode == OPQ);
      is_cond = (icode == JXX) | (icode == CMOVXX);
      cnd     = cnd_raw & is_cond;
      cc_d    = set_cc ? alu_cc : cc_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cc_q <= CC_RESET;
      else        cc_q <= cc_d;
   end

`ifdef CC_PERF_EN
   logic              retire_cond;
   logic [PERF_W-1:0] perf_cond_d;
   logic [PERF_W-1:0] perf_taken_d;
   logic [PERF_W-1:0] perf_cond_q;
   logic [PERF_W-1:0] perf_taken_q;

   always_comb begin
      retire_cond  = in_valid & ~stall & stat_ok & is_cond;
      perf_cond_d  = perf_cond_q;
      perf_taken_d = perf_taken_q;
      if (retire_cond) begin
         perf_cond_d = perf_cond_q + PERF_W'(1);
         if (cnd) perf_taken_d = perf_taken_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_cond_q  <= '0;
         perf_taken_q <= '0;
      end else begin
         perf_cond_q  <= perf_cond_d;
         perf_taken_q <= perf_taken_d;
      end
   end

   assign perf_cond  = perf_cond_q;
   assign perf_taken = perf_taken_q;
`else
   assign perf_cond  = '0;
   assign perf_taken = '0;
`endif

endmodule

// File: tb/tb_cc_cond_unit.sv
module tb_cc_cond_unit;

   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, stall, stat_ok;
   logic [3:0]    icode, ifun;
   logic [2:0]    alu_cc;
   logic [2:0]    cc_q;
   logic          cnd, set_cc;
   logic [PW-1:0] perf_cond, perf_taken;

   int errors = 0;
   int checks = 0;

   // reference state
   logic [2:0] m_cc;
   int         m_pc, m_pt;

   always #5 clk = ~clk;

   cc_cond_unit #(.CC_RESET(3'b100), .PERF_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
      .stat_ok(stat_ok), .icode(icode), .ifun(ifun), .alu_cc(alu_cc),
      .cc_q(cc_q), .cnd(cnd), .set_cc(set_cc),
      .perf_cond(perf_cond), .perf_taken(perf_taken)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // condition semantics stated as comparisons on the flags
   function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                    input logic [2:0] cc);
      bit zf, less;
      zf   = cc[2];
      less = (cc[1] != cc[0]);
      if (ic != 4'h7 && ic != 4'h2) return 1'b0;
      case (int'(fn))
         0: return 1'b1;
         1: return less || zf;
         2: return less;
         3: return zf;
         4: return !zf;
         5: return !less;
         6: return !less && !zf;
         default: return 1'b0;
      endcase
   endfunction

   // one cycle: drive, check combinational/registered outputs at negedge,
   // advance the reference at posedge
   task automatic cyc(input logic r, input logic v, input logic s, input logic ok,
                      input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] a);
      bit exp_set, exp_cnd, retire;
      rst_n = r; in_valid = v; stall = s; stat_ok = ok;
      icode = ic; ifun = fn; alu_cc = a;
      exp_set = v && !s && ok && (ic == 4'h6);
      exp_cnd = ref_cnd(ic, fn, m_cc);
      @(negedge clk);
      chk("cc_q", 32'(cc_q), 32'(m_cc));
      chk("cnd", 32'(cnd), 32'(exp_cnd));
      chk("set_cc", 32'(set_cc), 32'(exp_set));
`ifdef CC_PERF_EN
      chk("perf_cond", 32'(perf_cond), 32'(m_pc));
      chk("perf_taken", 32'(perf_taken), 32'(m_pt));
`else
      chk("perf_cond_tied", 32'(perf_cond), 32'd0);
      chk("perf_taken_tied", 32'(perf_taken), 32'd0);
`endif
      @(posedge clk);
      retire = v && !s && ok && (ic == 4'h7 || ic == 4'h2);
      if (!r) begin
         m_cc = 3'b100; m_pc = 0; m_pt = 0;
      end else begin
         if (exp_set) m_cc = a;
         if (retire) begin
            m_pc = (m_pc + 1) % (1 << PW);
            if (exp_cnd) m_pt = (m_pt + 1) % (1 << PW);
         end
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; stat_ok = 1'b1;
      icode = 4'h0; ifun = 4'h0; alu_cc = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      m_cc = 3'b100; m_pc = 0; m_pt = 0;

      // 1. reset flags: je taken, jne not taken
      cyc(1, 1, 0, 1, 4'h7, 4'h3, 3'b000);
      chk("t1_je", 32'(cnd), 32'd1);
      cyc(1, 1, 0, 1, 4'h7, 4'h4, 3'b000);
      chk("t1_jne", 32'(cnd), 32'd0);

      // 2. OPq sets SF
      cyc(1, 1, 0, 1, 4'h6, 4'h0, 3'b010);
      cyc(1, 1, 0, 1, 4'h7, 4'h2, 3'b000);
      chk("t2_cc", 32'(cc_q), 32'h2);
      chk("t2_jl", 32'(cnd), 32'd1);
      cyc(1, 1, 0, 1, 4'h7, 4'h5, 3'b000);
      chk("t2_jge", 32'(cnd), 32'd0);

      // 3. stalled / faulting OPq leave flags alone
      cyc(1, 1, 1, 1, 4'h6, 4'h0, 3'b011);
      cyc(1, 1, 0, 0, 4'h6, 4'h0, 3'b011);
      cyc(1, 0, 0, 1, 4'h6, 4'h0, 3'b011);
      cyc(1, 0, 0, 1, 4'h0, 4'h0, 3'b000);
      chk("t3_hold", 32'(cc_q), 32'h2);

      // 4. full sweep of flags x ifun for JXX, CMOVXX and a non-conditional icode
      for (int c = 0; c < 8; c++) begin
         cyc(1, 1, 0, 1, 4'h6, 4'h0, 3'(c));
         for (int f = 0; f < 16; f++) begin
            cyc(1, 1, 0, 1, 4'h7, 4'(f), 3'b111);
            cyc(1, 0, 0, 1, 4'h2, 4'(f), 3'b111);
            cyc(1, 1, 0, 1, 4'h3, 4'(f), 3'b111);
         end
      end

      // 5. reset wins over a simultaneous CC write
      cyc(1, 1, 0, 1, 4'h6, 4'h0, 3'b010);
      cyc(0, 1, 0, 1, 4'h6, 4'h0, 3'b001);
      cyc(1, 0, 0, 1, 4'h0, 4'h0, 3'b000);
      chk("t5_rst", 32'(cc_q), 32'h4);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [3:0] ic;
         case ($urandom_range(0, 4))
            0: ic = 4'h6;
            1: ic = 4'h7;
            2: ic = 4'h2;
            default: ic = 4'($urandom);
         endcase
         cyc(($urandom_range(0, 49) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) != 0), ic, 4'($urandom_range(0, 9)), 3'($urandom));
      end

`ifdef CC_PERF_EN
      // 6. counter wrap: 18 retired JXX (10 taken), plus two that do not retire
      cyc(0, 0, 0, 1, 4'h0, 4'h0, 3'b000);
      for (int i = 0; i < 18; i++)
         cyc(1, 1, 0, 1, 4'h7, (i < 10) ? 4'h3 : 4'h4, 3'b000);
      cyc(1, 1, 1, 1, 4'h7, 4'h3, 3'b000);
      cyc(1, 1, 0, 0, 4'h7, 4'h3, 3'b000);
      cyc(1, 0, 0, 1, 4'h0, 4'h0, 3'b000);
      chk("t6_perf_cond", 32'(perf_cond), 32'd2);
      chk("t6_perf_taken", 32'(perf_taken), 32'd10);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
